// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request and response, fixed LATENCY.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing them aligned.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW+1:0]   addr_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;

  logic            from_req;
  logic            enter_resp;
  logic [AW+1:0]   op_addr;
  logic            op_we;
  logic [1:0]      op_size;
  logic            op_uns;
  logic [31:0]     op_wdata;

  logic            is_half, is_word, misalign, trap;
  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic [31:0]     rd_word, wr_word, sh_word, ld_data, rdata_d;

  logic            unused_addr;
  assign unused_addr = ^req_addr_i[31:AW+2];

  // Power-up contents are zero; reset never touches storage.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == StIdle && req_valid_i) begin
      addr_q  <= req_addr_i[AW+1:0];
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
    end
  end

  // With LATENCY = 1 the acceptance edge is also the access edge, so use the live request.
  assign from_req   = (state_q == StIdle);
  assign enter_resp = (from_req && req_valid_i && (LATENCY == 1)) ||
                      (state_q == StWait && cnt_q == '0);

  assign op_addr  = from_req ? req_addr_i[AW+1:0] : addr_q;
  assign op_we    = from_req ? req_we_i           : we_q;
  assign op_size  = from_req ? req_size_i         : size_q;
  assign op_uns   = from_req ? req_unsigned_i     : uns_q;
  assign op_wdata = from_req ? req_wdata_i        : wdata_q;

  assign is_half  = (op_size == 2'b01);
  assign is_word  = op_size[1];
  assign misalign = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));
  // Byte lane of the access; dropping the low bits forces half/word aligned.
  assign lane     = is_word ? 2'b00 : (is_half ? {op_addr[1], 1'b0} : op_addr[1:0]);
  assign idx      = op_addr[AW+1:2];
  assign rd_word  = mem_q[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign trap            = 1'b0;
`endif

  always_comb begin
    wr_word = rd_word;
    if (is_word)      wr_word = op_wdata;
    else if (is_half) wr_word[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
    else              wr_word[{lane, 3'b000} +: 8]      = op_wdata[7:0];
  end

  always_comb begin
    sh_word = rd_word >> {lane, 3'b000};
    if (is_word)      ld_data = rd_word;
    else if (is_half) ld_data = {{16{~op_uns & sh_word[15]}}, sh_word[15:0]};
    else              ld_data = {{24{~op_uns & sh_word[7]}}, sh_word[7:0]};
    rdata_d = (op_we || trap) ? '0 : ld_data;
  end

  always_ff @(posedge clk_i) begin
    if (enter_resp && op_we && !trap) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         rdata_q <= '0;
    else if (enter_resp) rdata_q <= rdata_d;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         err_q <= 1'b0;
    else if (enter_resp) err_q <= trap;
  end
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in storage; a power of two of at least 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; minimum 1.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  the MEM stage presents an access request.
REQ-006 req_ready_o  output  1  the responder can accept a request.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_we_i  input  1  1 = store, 0 = load.
REQ-009 req_size_i  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-010 req_unsigned_i  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 req_wdata_i  input  32  store data, taken from the low bits.
REQ-012 rsp_valid_o  output  1  a response is available.
REQ-013 rsp_ready_i  input  1  the MEM stage consumes the response.
REQ-014 rsp_rdata_o  output  32  extended load data; 0 for stores.
REQ-015 rsp_err_o  output  1  the access was misaligned and suppressed.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1; on acceptance, addr, we, size, unsigned and wdata SHALL be latched.
REQ-018 On acceptance with LATENCY = 1, the FSM SHALL go from IDLE to RESP; otherwise it SHALL go to WAIT with the counter loaded with LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go to RESP on that edge.
REQ-020 rsp_valid_o SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-021 The storage read or write SHALL be performed on the edge that enters RESP, and the response data SHALL be registered on that same edge.
REQ-022 In RESP, rsp_valid_o SHALL stay 1 and rsp_rdata_o and rsp_err_o SHALL stay stable until rsp_ready_i is 1; on that edge the FSM SHALL return to IDLE.
REQ-023 Only one request SHALL be outstanding at a time; a new request SHALL be accepted no earlier than the cycle after the response handshake (no acceptance while in RESP).
REQ-024 The word index SHALL be req_addr_i[31:2] modulo DEPTH_WORDS, so addresses wrap silently with no error.
REQ-025 A byte store SHALL write only the lane selected by addr[1:0], and a half store SHALL write only the lanes selected by addr[1]; other bytes SHALL be unchanged.
REQ-026 A load SHALL extract the addressed byte or half, then extend it to 32 bits according to req_unsigned_i; a word load SHALL be returned unchanged.
REQ-027 Misalignment is defined as: half with addr[0] = 1, or word with addr[1:0] != 00.
REQ-028 req_valid_i SHALL be ignored outside IDLE, and inputs SHALL not be sampled after acceptance.

Reset
REQ-029 While rstn_i is 0: the FSM SHALL be IDLE, the counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0; req_ready_o SHALL be 1 once rstn_i is released.
REQ-030 A reset asserted in WAIT SHALL abort the access so that no storage write occurs; a reset asserted in RESP SHALL drop the pending response.
REQ-031 Storage contents SHALL not be cleared by reset; they SHALL be initialised to 0 at time zero only.

Configuration
REQ-032 The feature SHALL be controlled by the macro DMEM_MISALIGN_TRAP_EN.
REQ-033 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL respond with rsp_err_o = 1 and rsp_rdata_o = 0, SHALL not write storage, and SHALL keep normal latency.
REQ-034 Without DMEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be forced aligned (half clears addr[0], word clears addr[1:0]), and rsp_err_o SHALL be tied to 0.

Verification
REQ-035 LATENCY = 2: word store 0xDEADBEEF to 0x10, then word load 0x10 -> rsp_valid_o 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-036 Byte store 0x80 to 0x13, then byte load of 0x13 signed and unsigned -> 0xFFFFFF80 and 0x00000080; word load 0x10 -> 0x80ADBEEF.
REQ-037 Hold rsp_ready_i = 0 for 5 cycles in RESP while req_valid_i = 1 -> rsp data stable, req_ready_o = 0, no second accept; accept occurs the cycle after the handshake.
REQ-038 Half store 0x1234 to 0x11 -> with DMEM_MISALIGN_TRAP_EN: err = 1 and word 0x10 unchanged; without it: err = 0 and word 0x10 low half = 0x1234.
REQ-039 DEPTH_WORDS = 1024: store 0x55 to address 0x1000 -> load of address 0x0 returns 0x55 (wrap).
REQ-040 LATENCY = 3: assert rstn_i one cycle after accepting store 0xAAAAAAAA to 0x20 -> no response; a subsequent load of 0x20 returns the prior value 0.
